// File: rtl/instr_loader_pkg.sv
// Shared constants and state encoding for the byte-serial instruction loader.
package instr_loader_pkg;

  localparam logic [7:0]  START_MARK = 8'hFE;
  localparam logic [7:0]  END_MARK   = 8'hFF;
  localparam logic [31:0] NOP_WORD   = 32'h00000013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/instr_byte_packer.sv
// Little-endian 4-byte accumulator; word_done fires combinationally on the byte
// that completes a word, with the full word presented alongside it.
module instr_byte_packer (
  input  logic        clk_i,
  input  logic        reset,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_in,
  output logic [1:0]  byte_idx,
  output logic        word_done,
  output logic [31:0] word
);

  logic [23:0] acc_q;

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      byte_idx <= 2'd0;
      acc_q    <= 24'd0;
    end else if (clear) begin
      byte_idx <= 2'd0;
    end else if (accept) begin
      case (byte_idx)
        2'd0:    acc_q[7:0]   <= byte_in;
        2'd1:    acc_q[15:8]  <= byte_in;
        2'd2:    acc_q[23:16] <= byte_in;
        default: acc_q        <= acc_q;
      endcase
      byte_idx <= byte_idx + 2'd1;
    end
  end

  assign word_done = accept && (byte_idx == 2'd3);
  assign word      = {byte_in, acc_q};

endmodule

// File: rtl/instr_loader.sv
// Instruction loader: detects FE/FF framing, packs bytes into words and writes them
// to instruction memory. Optional NOP padding: INSTR_LOADER_NOP_FILL_EN.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk_i,
  input  logic              reset,
  input  logic [7:0]        instr_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [31:0]       wr_data_o,
  output logic [ADDR_W:0]   word_count_o,
  output logic              load_done_o,
  output logic              err_o
);

  state_t              state_q, state_n;
  logic                wr_en_n, done_n, err_n;
  logic [ADDR_W-1:0]   wr_addr_n;
  logic [31:0]         wr_data_n;
  logic [ADDR_W:0]     count_n;
  logic [1:0]          byte_idx;
  logic                word_done, accept, clear;
  logic [31:0]         word;
  logic                is_start, is_end, at_marker_slot;

  assign is_start       = (instr_i == START_MARK);
  assign is_end         = (instr_i == END_MARK);
  assign at_marker_slot = (byte_idx == 2'd0);
  // Markers only count at the opcode byte; elsewhere FE/FF are plain data.
  assign accept = (state_q == LOAD) && !(at_marker_slot && (is_start || is_end));
  assign clear  = (state_q != LOAD);

  instr_byte_packer u_packer (
    .clk_i     (clk_i),
    .reset     (reset),
    .clear     (clear),
    .accept    (accept),
    .byte_in   (instr_i),
    .byte_idx  (byte_idx),
    .word_done (word_done),
    .word      (word)
  );

`ifdef INSTR_LOADER_NOP_FILL_EN
  logic [ADDR_W-1:0] fill_q, fill_n;
`endif

  always_comb begin
    state_n   = state_q;
    wr_en_n   = 1'b0;
    wr_addr_n = wr_addr_o;
    wr_data_n = wr_data_o;
    count_n   = word_count_o;
    done_n    = load_done_o;
    err_n     = err_o;
`ifdef INSTR_LOADER_NOP_FILL_EN
    fill_n    = fill_q;
`endif
    case (state_q)
      IDLE: if (is_start) state_n = LOAD;
      LOAD: begin
        if (at_marker_slot && is_end) begin
`ifdef INSTR_LOADER_NOP_FILL_EN
          if (word_count_o[ADDR_W]) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            state_n = FILL;
            fill_n  = word_count_o[ADDR_W-1:0];
          end
`else
          state_n = DONE;
          done_n  = 1'b1;
`endif
        end else if (at_marker_slot && is_start) begin
          err_n = 1'b1;
        end else if (word_done) begin
          // Top bit of the count set means memory is already full.
          if (word_count_o[ADDR_W]) begin
            err_n = 1'b1;
          end else begin
            wr_en_n   = 1'b1;
            wr_addr_n = word_count_o[ADDR_W-1:0];
            wr_data_n = word;
            count_n   = word_count_o + 1'b1;
          end
        end
      end
`ifdef INSTR_LOADER_NOP_FILL_EN
      FILL: begin
        wr_en_n   = 1'b1;
        wr_addr_n = fill_q;
        wr_data_n = NOP_WORD;
        fill_n    = fill_q + 1'b1;
        // done_n is raised from DONE so it lands one edge after the last write.
        if (&fill_q) state_n = DONE;
      end
`endif
      DONE:    done_n  = 1'b1;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      wr_en_o      <= 1'b0;
      wr_addr_o    <= '0;
      wr_data_o    <= 32'd0;
      word_count_o <= '0;
      load_done_o  <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      state_q      <= state_n;
      wr_en_o      <= wr_en_n;
      wr_addr_o    <= wr_addr_n;
      wr_data_o    <= wr_data_n;
      word_count_o <= count_n;
      load_done_o  <= done_n;
      err_o        <= err_n;
    end
  end

`ifdef INSTR_LOADER_NOP_FILL_EN
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) fill_q <= '0;
    else       fill_q <= fill_n;
  end
`endif

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: a behavioural model queues expected writes
// as bytes are driven; a negedge monitor pops and compares each write pulse.
module tb_instr_loader;
  import instr_loader_pkg::*;

  localparam int ADDR_W = 6;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk_i = 1'b0;
  logic              reset;
  logic [7:0]        instr_i;
  logic              wr_en_o;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [31:0]       wr_data_o;
  logic [ADDR_W:0]   word_count_o;
  logic              load_done_o;
  logic              err_o;

  instr_loader #(.ADDR_W(ADDR_W)) dut (
    .clk_i        (clk_i),
    .reset        (reset),
    .instr_i      (instr_i),
    .wr_en_o      (wr_en_o),
    .wr_addr_o    (wr_addr_o),
    .wr_data_o    (wr_data_o),
    .word_count_o (word_count_o),
    .load_done_o  (load_done_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t  exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   n_writes = 0;

  int          m_st;
  int          m_idx;
  int          m_count;
  logic [31:0] m_word;
  logic        m_err;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (!reset && wr_en_o) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        chk("spurious_write", 64'(exp_q.size()), 64'd1);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 64'(wr_addr_o), 64'(e.addr));
        chk("wr_data", 64'(wr_data_o), 64'(e.data));
      end
    end
  end

  function automatic logic done_at_end();
`ifdef INSTR_LOADER_NOP_FILL_EN
    return m_count == DEPTH;
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_byte(input logic [7:0] b);
    wr_t e;
    case (m_st)
      0: if (b == 8'hFE) begin m_st = 1; m_idx = 0; end
      1: begin
        if (m_idx == 0 && b == 8'hFF) begin
`ifdef INSTR_LOADER_NOP_FILL_EN
          for (int a = m_count; a < DEPTH; a++) begin
            e.addr = a[ADDR_W-1:0];
            e.data = 32'h00000013;
            exp_q.push_back(e);
          end
`endif
          m_st = 2;
        end else if (m_idx == 0 && b == 8'hFE) begin
          m_err = 1'b1;
        end else begin
          m_word[8*m_idx +: 8] = b;
          if (m_idx == 3) begin
            if (m_count < DEPTH) begin
              e.addr = m_count[ADDR_W-1:0];
              e.data = m_word;
              exp_q.push_back(e);
              m_count++;
            end else begin
              m_err = 1'b1;
            end
            m_idx = 0;
          end else begin
            m_idx++;
          end
        end
      end
      default: ;
    endcase
  endtask

  task automatic send(input logic [7:0] b);
    instr_i = b;
    model_byte(b);
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send(w[8*k +: 8]);
  endtask

  task automatic apply_reset();
    #1;
    reset   = 1'b1;
    instr_i = 8'h00;
    #1;
    chk("rst_wr_en",   64'(wr_en_o),      64'd0);
    chk("rst_wr_addr", 64'(wr_addr_o),    64'd0);
    chk("rst_wr_data", 64'(wr_data_o),    64'd0);
    chk("rst_count",   64'(word_count_o), 64'd0);
    chk("rst_done",    64'(load_done_o),  64'd0);
    chk("rst_err",     64'(err_o),        64'd0);
    exp_q.delete();
    m_st = 0; m_idx = 0; m_count = 0; m_word = '0; m_err = 1'b0;
    @(posedge clk_i);
    #1;
    reset = 1'b0;
  endtask

  task automatic finish_load(input string tag, input int exp_cnt, input logic exp_err);
    for (int i = 0; i < 200 && (exp_q.size() != 0 || !load_done_o); i++) send(8'h00);
    send(8'h00);
    chk({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    chk({tag, "_count"},   64'(word_count_o), 64'(exp_cnt));
    chk({tag, "_err"},     64'(err_o),        64'(exp_err));
    chk({tag, "_done"},    64'(load_done_o),  64'd1);
  endtask

  initial begin
    int n0;
    logic [31:0] w;
    reset   = 1'b1;
    instr_i = 8'h00;
    apply_reset();

    // basic two-word load
    send(8'hFE);
    send_word(32'h00000013);
    send_word(32'h00500093);
    send(8'hFF);
    chk("basic_done_at_ff", 64'(load_done_o), 64'(done_at_end()));
    finish_load("basic", 2, 1'b0);

    // junk before the start marker is ignored
    apply_reset();
    n0 = n_writes;
    send(8'h00); send(8'h37); send(8'h13);
    chk("prestart_no_write", 64'(n_writes - n0), 64'd0);
    send(8'hFE);
    send_word(32'h00000013);
    send(8'hFF);
    finish_load("prestart", 1, 1'b0);

    // FE/FF inside a word are data
    apply_reset();
    send(8'hFE);
    send(8'h13); send(8'h00); send(8'hFF); send(8'hFE);
    send(8'hFF);
    chk("mdata_done_at_ff", 64'(load_done_o), 64'(done_at_end()));
    finish_load("mdata", 1, 1'b0);

    // misplaced start marker: error, byte dropped, load continues
    apply_reset();
    send(8'hFE);
    send(8'hFE);
    chk("misplaced_err", 64'(err_o), 64'd1);
    send_word(32'h12345637);
    send(8'hFF);
    finish_load("misplaced", 1, 1'b1);

    // overflow: 65 words into 64 slots
    apply_reset();
    n0 = n_writes;
    send(8'hFE);
    for (int i = 0; i < DEPTH + 1; i++) begin
      w = $urandom();
      w[7:0] = 8'($urandom_range(0, 253));
      send_word(w);
    end
    chk("ovf_err_before_end", 64'(err_o), 64'd1);
    send(8'hFF);
    chk("ovf_done_at_ff", 64'(load_done_o), 64'd1);
    finish_load("ovf", DEPTH, 1'b1);
    chk("ovf_write_pulses", 64'(n_writes - n0), 64'(DEPTH));

    // reset mid-word drops the partial word
    apply_reset();
    send(8'hFE);
    send(8'h13); send(8'h00);
    apply_reset();
    send(8'hFE);
    send_word(32'h00500093);
    send(8'hFF);
    finish_load("midrst", 1, 1'b0);

    // DONE ignores further input
    n0 = n_writes;
    send(8'hFE);
    send_word(32'h00000013);
    send(8'hFF);
    chk("done_ignores_writes", 64'(n_writes - n0), 64'd0);
    chk("done_ignores_count",  64'(word_count_o), 64'd1);

`ifdef INSTR_LOADER_NOP_FILL_EN
    // NOP fill timing: back-to-back writes, done one edge after addr 63
    begin
      logic prev_en;
      logic [ADDR_W-1:0] prev_addr;
      int run;
      logic seen;
      apply_reset();
      send(8'hFE);
      send_word(32'h00000013);
      send_word(32'h00500093);
      instr_i = 8'hFF;
      model_byte(8'hFF);
      @(posedge clk_i); #1;
      chk("fill_done_low_at_ff", 64'(load_done_o), 64'd0);
      instr_i = 8'h00;
      prev_en = 1'b0; prev_addr = '0; run = 0; seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
        @(posedge clk_i); #1;
        if (load_done_o) begin
          seen = 1'b1;
          chk("fill_last_en",   64'(prev_en),   64'd1);
          chk("fill_last_addr", 64'(prev_addr), 64'(DEPTH - 1));
          chk("fill_en_after",  64'(wr_en_o),   64'd0);
        end else if (wr_en_o) begin
          run++;
        end
        prev_en = wr_en_o; prev_addr = wr_addr_o;
      end
      chk("fill_done_seen", 64'(seen), 64'd1);
      chk("fill_run_len",   64'(run),  64'(DEPTH - 2));
      finish_load("fill", 2, 1'b0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
